fd34_bank_arbiter: RTL and testbench

//   Round-robin arbiter and sequencer sharing one bank of NREG 4-bit FD34-style registers among NREQ requesters.

---
 rtl/fd34_arb_pkg.sv | 25 ++
 rtl/fd34_rr_pick.sv | 48 ++++
 rtl/fd34_bank_arbiter.sv | 164 ++++++++++++++++
 tb/tb_fd34_bank_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fd34_arb_pkg.sv
// ----------------------------------------------------------------------------
// fd34_arb_pkg : shared op/state encodings and constants for fd34_bank_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fd34_arb_pkg;
  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_SET   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  localparam logic [3:0] ALL_ONES4  = 4'hF;
  localparam logic [3:0] ALL_ZEROS4 = 4'h0;
endpackage

`default_nettype wire

// File: rtl/fd34_rr_pick.sv
// ----------------------------------------------------------------------------
// fd34_rr_pick : combinational round-robin picker (first request at/after ptr)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fd34_rr_pick
  import fd34_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;

  // Rotating the request vector puts the pointer at bit 0, so a plain
  // low-to-high priority scan yields the round-robin winner.
  assign w_dbl = {req_i, req_i} >> ptr_i;
  assign w_rot = w_dbl[NREQ-1:0];

  always_comb begin
    int sum;
    logic found;
    sum      = 0;
    found    = 1'b0;
    idx_o    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && w_rot[k]) begin
        found = 1'b1;
        sum   = int'(ptr_i) + k;
        if (sum >= NREQ) sum = sum - NREQ;
        idx_o = IW'(sum);
      end
    end
    valid_o  = found;
    onehot_o = found ? (NREQ'(1) << idx_o) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/fd34_bank_arbiter.sv
// ----------------------------------------------------------------------------
// fd34_bank_arbiter : round-robin sequencer driving a bank of 4-bit registers.
// Optional request masking via macro FD34_ARB_MASK_EN (adds REQ_MASK).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fd34_bank_arbiter
  import fd34_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int NREG    = 8,
  parameter int AW      = 3,
  parameter int RCV_CYC = 1
) (
  input  logic               CP,
  input  logic               CD,
  input  logic [NREQ-1:0]    REQ,
`ifdef FD34_ARB_MASK_EN
  input  logic [NREQ-1:0]    REQ_MASK,
`endif
  input  logic [2*NREQ-1:0]  OP,
  input  logic [AW*NREQ-1:0] ADDR,
  input  logic [4*NREQ-1:0]  DATA,
  output logic [NREQ-1:0]    GNT,
  output logic               BUSY,
  output logic [NREG-1:0]    WE,
  output logic [3:0]         WD,
  output logic               WCLR,
  output logic               WSET,
  output logic               ERR
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, win_q, win_d;
  logic [2:0]      rcv_q, rcv_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREG-1:0] we_q, we_d;
  logic [3:0]      wd_q, wd_d;
  logic            wclr_q, wclr_d, wset_q, wset_d, err_q, err_d, busy_q, busy_d;

  logic [NREQ-1:0] w_req_eff, w_pick_onehot;
  logic [IW-1:0]   w_pick_idx;
  logic            w_pick_valid;
  op_e             w_op;
  logic [AW-1:0]   w_addr;
  logic [3:0]      w_data;
  logic            w_inrange;
  logic [NREG-1:0] w_dec;

`ifdef FD34_ARB_MASK_EN
  assign w_req_eff = REQ & ~REQ_MASK;
`else
  assign w_req_eff = REQ;
`endif

  fd34_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i    (w_req_eff),
    .ptr_i    (ptr_q),
    .onehot_o (w_pick_onehot),
    .idx_o    (w_pick_idx),
    .valid_o  (w_pick_valid)
  );

  assign w_op      = op_e'(OP[2*int'(w_pick_idx) +: 2]);
  assign w_addr    = ADDR[AW*int'(w_pick_idx) +: AW];
  assign w_data    = DATA[4*int'(w_pick_idx) +: 4];
  assign w_inrange = (32'(w_addr) < NREG);

  always_comb begin
    w_dec = '0;
    for (int i = 0; i < NREG; i++) w_dec[i] = (32'(w_addr) == i);
  end

  // The issue-cycle outputs are computed while sampling in IDLE and land in
  // the output registers on the same edge that enters ISSUE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    rcv_d   = rcv_q;
    gnt_d   = '0;
    we_d    = '0;
    wd_d    = ALL_ZEROS4;
    wclr_d  = 1'b0;
    wset_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_pick_valid) begin
          state_d = ST_ISSUE;
          win_d   = w_pick_idx;
          gnt_d   = w_pick_onehot;
          if (!w_inrange) begin
            err_d = 1'b1;
          end else begin
            case (w_op)
              OP_NOP:   ;
              OP_LOAD:  begin we_d = w_dec; wd_d = w_data; end
              OP_CLEAR: begin we_d = w_dec; wclr_d = 1'b1; end
              OP_SET:   begin we_d = w_dec; wd_d = ALL_ONES4; wset_d = 1'b1; end
            endcase
          end
        end
      end
      ST_ISSUE: begin
        ptr_d = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        if (RCV_CYC == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RECOVER;
          rcv_d   = 3'(RCV_CYC - 1);
        end
      end
      ST_RECOVER: begin
        if (rcv_q == 3'd0) state_d = ST_IDLE;
        else               rcv_d   = rcv_q - 3'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CP or posedge CD) begin
    if (CD) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      rcv_q   <= '0;
      gnt_q   <= '0;
      we_q    <= '0;
      wd_q    <= ALL_ZEROS4;
      wclr_q  <= 1'b0;
      wset_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      rcv_q   <= rcv_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      wclr_q  <= wclr_d;
      wset_q  <= wset_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign GNT  = gnt_q;
  assign WE   = we_q;
  assign WD   = wd_q;
  assign WCLR = wclr_q;
  assign WSET = wset_q;
  assign ERR  = err_q;
  assign BUSY = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_fd34_bank_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fd34_bank_arbiter : scoreboard bench for fd34_bank_arbiter (NREG=6)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_fd34_bank_arbiter;
  localparam int NREQ = 4, NREG = 6, AW = 3, RCV_CYC = 1;

  logic               CP = 1'b0;
  logic               CD = 1'b1;
  logic [NREQ-1:0]    REQ = '0;
  logic [2*NREQ-1:0]  OP = '0;
  logic [AW*NREQ-1:0] ADDR = '0;
  logic [4*NREQ-1:0]  DATA = '0;
  logic [NREQ-1:0]    GNT;
  logic               BUSY, WCLR, WSET, ERR;
  logic [NREG-1:0]    WE;
  logic [3:0]         WD;
`ifdef FD34_ARB_MASK_EN
  logic [NREQ-1:0]    REQ_MASK = '0;
`endif

  fd34_bank_arbiter #(.NREQ(NREQ), .NREG(NREG), .AW(AW), .RCV_CYC(RCV_CYC)) dut (
    .CP(CP), .CD(CD), .REQ(REQ),
`ifdef FD34_ARB_MASK_EN
    .REQ_MASK(REQ_MASK),
`endif
    .OP(OP), .ADDR(ADDR), .DATA(DATA), .GNT(GNT), .BUSY(BUSY),
    .WE(WE), .WD(WD), .WCLR(WCLR), .WSET(WSET), .ERR(ERR)
  );

  always #5 CP = ~CP;

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic [NREG-1:0] we;
    logic [3:0]      wd;
    logic            wclr;
    logic            wset;
    logic            err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;

  task automatic check(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    vectors++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act_v, exp_v, $time);
    end
  endtask

  // Reference model: one op per 2+RCV_CYC cycles, winner found by scanning
  // from the rotating pointer.
  int   ptr_m = 0, cd_m = 0, w_m, a_m, o_m;
  logic busy_m = 1'b0;
  logic [NREQ-1:0] eff_m;
  exp_t e_m;

  initial forever begin
    @(posedge CP or posedge CD);
    if (CD) begin
      ptr_m = 0; cd_m = 0; busy_m = 1'b0;
      exp_q.delete();
    end else begin
      eff_m = REQ;
`ifdef FD34_ARB_MASK_EN
      eff_m = REQ & ~REQ_MASK;
`endif
      if (cd_m > 0) begin
        cd_m--;
      end else if (eff_m != 0) begin
        w_m = -1;
        for (int k = 0; k < NREQ; k++)
          if (w_m < 0 && eff_m[(ptr_m + k) % NREQ]) w_m = (ptr_m + k) % NREQ;
        e_m = '0;
        e_m.gnt[w_m] = 1'b1;
        a_m = int'(ADDR[w_m*AW +: AW]);
        o_m = int'(OP[w_m*2 +: 2]);
        if (a_m >= NREG) begin
          e_m.err = 1'b1;
        end else begin
          case (o_m)
            1: begin e_m.we[a_m] = 1'b1; e_m.wd = DATA[w_m*4 +: 4]; end
            2: begin e_m.we[a_m] = 1'b1; e_m.wclr = 1'b1; end
            3: begin e_m.we[a_m] = 1'b1; e_m.wd = 4'hF; e_m.wset = 1'b1; end
            default: ;
          endcase
        end
        exp_q.push_back(e_m);
        ptr_m = (w_m + 1) % NREQ;
        cd_m  = 1 + RCV_CYC;
      end
      busy_m = (cd_m != 0);
    end
  end

  // Monitor: any DUT activity must match the oldest expected op.
  exp_t e_mon;
  initial forever begin
    @(negedge CP);
    if (!CD) begin
      check("busy", 32'(BUSY), 32'(busy_m));
      if (GNT != 0 || WE != 0 || ERR || WCLR || WSET) begin
        if (exp_q.size() == 0) begin
          check("spurious_op", 32'({GNT, WE, WD, WCLR, WSET, ERR}), 32'(0));
        end else begin
          e_mon = exp_q.pop_front();
          check("scoreboard", 32'({GNT, WE, WD, WCLR, WSET, ERR}), 32'(e_mon));
        end
      end else if (exp_q.size() != 0) begin
        e_mon = exp_q.pop_front();
        check("missing_op", 32'(0), 32'(e_mon));
      end
    end
  end

  // Requester behaviour
  logic       act[NREQ];
  logic [1:0] op_a[NREQ];
  logic [2:0] addr_a[NREQ];
  logic [3:0] data_a[NREQ];
  int         mode = 2;  // 0 random, 1 always re-request, 2 directed only

  task automatic pack();
    for (int i = 0; i < NREQ; i++) begin
      REQ[i]           = act[i];
      OP[i*2 +: 2]     = act[i] ? op_a[i]   : 2'($urandom_range(3));
      ADDR[i*AW +: AW] = act[i] ? addr_a[i] : 3'($urandom_range(7));
      DATA[i*4 +: 4]   = act[i] ? data_a[i] : 4'($urandom_range(15));
    end
`ifdef FD34_ARB_MASK_EN
    REQ_MASK = (mode == 0 && $urandom_range(3) == 0) ? NREQ'($urandom) : '0;
`endif
  endtask

  task automatic step();
    logic dropped;
    @(negedge CP);
    for (int i = 0; i < NREQ; i++) begin
      dropped = 1'b0;
      if (act[i] && GNT[i]) begin
        act[i] = 1'b0;
      end else if (act[i] && mode == 0 && $urandom_range(31) == 0) begin
        act[i] = 1'b0;
        dropped = 1'b1;
      end
      if (!act[i] && !dropped && (mode == 1 || (mode == 0 && $urandom_range(2) == 0))) begin
        act[i]    = 1'b1;
        op_a[i]   = 2'($urandom_range(3));
        addr_a[i] = 3'($urandom_range(7));
        data_a[i] = 4'($urandom_range(15));
      end
    end
    pack();
  endtask

  task automatic run_until_gnt(input string nm, output bit got);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      if (GNT != 0) got = 1'b1;
    end
    if (!got) check({nm, "_timeout"}, 32'(0), 32'(1));
  endtask

  task automatic set_req(input int i, input logic [1:0] o, input logic [2:0] a, input logic [3:0] d);
    act[i] = 1'b1; op_a[i] = o; addr_a[i] = a; data_a[i] = d;
    pack();
  endtask

  task automatic drain();
    for (int i = 0; i < NREQ; i++) act[i] = 1'b0;
    pack();
    for (int c = 0; c < 10; c++) step();
  endtask

  bit got;
  int prev, idx, ngr;

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      act[i] = 1'b0; op_a[i] = '0; addr_a[i] = '0; data_a[i] = '0;
    end
    mode = 2;
    pack();
    repeat (3) @(negedge CP);
    check("reset_outputs", 32'({GNT, WE, WD, WCLR, WSET, ERR, BUSY}), 32'(0));
    CD = 1'b0;

    set_req(1, 2'b01, 3'd5, 4'hA);
    run_until_gnt("load", got);
    if (got) begin
      check("load_gnt", 32'(GNT), 32'(4'b0010));
      check("load_we", 32'(WE), 32'(6'h20));
      check("load_wd", 32'(WD), 32'(4'hA));
    end
    drain();

    set_req(0, 2'b10, 3'd3, 4'h7);
    run_until_gnt("clear", got);
    if (got) check("clear_we_wclr_wd", 32'({WE, WCLR, WSET, WD}), 32'({6'h08, 1'b1, 1'b0, 4'h0}));
    drain();
    set_req(0, 2'b11, 3'd3, 4'h2);
    run_until_gnt("set", got);
    if (got) check("set_we_wset_wd", 32'({WE, WCLR, WSET, WD}), 32'({6'h08, 1'b0, 1'b1, 4'hF}));
    drain();

    set_req(2, 2'b01, 3'd7, 4'h5);
    run_until_gnt("oor", got);
    if (got) check("oor_gnt_err_we", 32'({GNT, ERR, WE}), 32'({4'b0100, 1'b1, 6'h00}));
    drain();

    // All requesters held high: successive grants must rotate by one.
    mode = 1;
    for (int i = 0; i < NREQ; i++) set_req(i, 2'b01, 3'(i), 4'(i));
    prev = -1; ngr = 0;
    for (int c = 0; c < 60 && ngr < 8; c++) begin
      step();
      if (GNT != 0) begin
        idx = 0;
        for (int i = 0; i < NREQ; i++) if (GNT[i]) idx = i;
        if (prev >= 0) check("rr_order", 32'(idx), 32'((prev + 1) % NREQ));
        prev = idx; ngr++;
      end
    end
    if (ngr < 8) check("rr_timeout", 32'(ngr), 32'(8));
    mode = 2;
    drain();

    mode = 0;
    for (int c = 0; c < 3000; c++) step();
    mode = 2;
    drain();

    // Asynchronous reset in the middle of an issue cycle.
    set_req(0, 2'b01, 3'd2, 4'h5);
    run_until_gnt("midreset", got);
    if (got) check("midreset_we", 32'(WE), 32'(6'h04));
    #2 CD = 1'b1;
    #1 check("async_reset", 32'({GNT, WE, BUSY}), 32'(0));
    for (int i = 0; i < NREQ; i++) act[i] = 1'b0;
    pack();
    repeat (2) @(negedge CP);
    CD = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 2'b00, 3'd0, 4'h0);
    run_until_gnt("ptr_after_reset", got);
    if (got) check("ptr_after_reset", 32'(GNT), 32'(4'b0001));
    drain();
    if (exp_q.size() != 0) check("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
